// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator control stage.
//   Key codes, FSM state enum, operator enum and display constants.
package calc_pkg;

  localparam logic [4:0] KEY_ADD = 5'd16;
  localparam logic [4:0] KEY_SUB = 5'd17;
  localparam logic [4:0] KEY_EQU = 5'd18;
  localparam logic [4:0] KEY_CLR = 5'd19;

  localparam logic [4:0] DISP_16  = 5'b10000;
  localparam int         DISP_MIN = -15;

  typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, SHOW, ERR} fsm_t;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10} op_t;

  // Operator selected by an ADD/SUB key code.
  function automatic op_t key_op(input logic [4:0] k);
    return (k == KEY_SUB) ? OP_SUB : OP_ADD;
  endfunction

endpackage

// File: rtl/calc_if.sv
// calc_if: key input / display output bundle of the calculator.
//   key_valid, key_code : one-cycle key strobe and code (master -> slave)
//   state, err, op_ind  : display code, error flag, latched operator (slave -> master)
interface calc_if;
  logic       key_valid;
  logic [4:0] key_code;
  logic [4:0] state;
  logic       err;
  logic [1:0] op_ind;

  modport master (output key_valid, key_code, input state, err, op_ind);
  modport slave  (input key_valid, key_code, output state, err, op_ind);
endinterface

// File: rtl/calc_alu.sv
// calc_alu: combinational a op b on 4-bit unsigned operands.
//   a, b : operands; op : operator
//   disp : 5-bit display code of the result (two's complement low bits)
//   ovf  : result outside the displayable range -15..16
module calc_alu
  import calc_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  op_t        op,
  output logic [4:0] disp,
  output logic       ovf
);

  localparam logic signed [5:0] R_MAX = {1'b0, DISP_16};
  localparam logic signed [5:0] R_MIN = 6'(DISP_MIN);

  logic signed [5:0] r;

  always_comb begin
    r = 6'sd0;
    case (op)
      OP_ADD:  r = $signed({2'b00, a}) + $signed({2'b00, b});
      OP_SUB:  r = $signed({2'b00, a}) - $signed({2'b00, b});
      default: r = 6'sd0;
    endcase
    ovf  = (r > R_MAX) || (r < R_MIN);
    disp = r[4:0];
  end

endmodule

// File: rtl/calc_core.sv
// calc_core: calculator key FSM and result register feeding the 7-seg decoder.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : calc_if.slave (key_valid/key_code in; state/err/op_ind out)
//   ERR_HOLD   : cycles spent in ERR before auto-return (0 = wait for CLR)
// Build option: define CALC_SAT_EN to saturate EQU overflow to +16 instead
// of entering ERR.
module calc_core
  import calc_pkg::*;
#(
  parameter int ERR_HOLD = 0
) (
  input logic   clk,
  input logic   rst,
  calc_if.slave bus
);

  localparam int CW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

  fsm_t          fsm_q, fsm_d;
  logic [3:0]    a_q, a_d, b_q, b_d;
  op_t           op_q, op_d;
  logic [4:0]    disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [4:0] alu_disp;
  logic       alu_ovf;

  calc_alu u_alu (.a(a_q), .b(b_q), .op(op_q), .disp(alu_disp), .ovf(alu_ovf));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= ENTER_A;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_NONE;
      disp_q <= '0;
      cnt_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
    end
  end

  logic [4:0] k;
  logic       digit, opk, equ, clear;

  always_comb begin
    fsm_d  = fsm_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    disp_d = disp_q;
    cnt_d  = cnt_q;
    clear  = 1'b0;
    k      = bus.key_code;
    digit  = bus.key_valid && !k[4];
    opk    = bus.key_valid && (k == KEY_ADD || k == KEY_SUB);
    equ    = bus.key_valid && (k == KEY_EQU);

    if (bus.key_valid && k == KEY_CLR) begin
      clear = 1'b1;
    end else begin
      case (fsm_q)
        ENTER_A: begin
          if (digit) begin
            a_d    = k[3:0];
            disp_d = {1'b0, k[3:0]};
          end else if (opk) begin
            op_d  = key_op(k);
            fsm_d = OP_WAIT;
          end
        end
        OP_WAIT: begin
          if (digit) begin
            b_d    = k[3:0];
            disp_d = {1'b0, k[3:0]};
            fsm_d  = ENTER_B;
          end else if (opk) begin
            op_d = key_op(k);
          end
        end
        ENTER_B: begin
          if (digit) begin
            b_d    = k[3:0];
            disp_d = {1'b0, k[3:0]};
          end else if (equ) begin
            op_d = OP_NONE;
            if (!alu_ovf) begin
              disp_d = alu_disp;
              fsm_d  = SHOW;
            end else begin
`ifdef CALC_SAT_EN
              disp_d = DISP_16;
              fsm_d  = SHOW;
`else
              disp_d = '0;
              cnt_d  = '0;
              fsm_d  = ERR;
`endif
            end
          end
        end
        SHOW: begin
          if (digit) begin
            a_d    = k[3:0];
            b_d    = '0;
            disp_d = {1'b0, k[3:0]};
            fsm_d  = ENTER_A;
          end else if (opk && !disp_q[4]) begin
            // Only a 0..15 result fits back into operand a; 16 and
            // negatives leave the result on display.
            a_d   = disp_q[3:0];
            op_d  = key_op(k);
            fsm_d = OP_WAIT;
          end
        end
        ERR: begin
`ifndef CALC_SAT_EN
          if (ERR_HOLD > 0) begin
            if (int'(cnt_q) == ERR_HOLD - 1) clear = 1'b1;
            else                             cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        default: clear = 1'b1;
      endcase
    end

    if (clear) begin
      fsm_d  = ENTER_A;
      a_d    = '0;
      b_d    = '0;
      op_d   = OP_NONE;
      disp_d = '0;
      cnt_d  = '0;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.state  = disp_q;
    bus.op_ind = op_q;
`ifdef CALC_SAT_EN
    bus.err    = 1'b0;
`else
    bus.err    = (fsm_q == ERR);
`endif
  end

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: scoreboard bench for calc_core (ERR_HOLD=4). A driver issues
// keys on the falling edge and pushes the reference model's expected outputs;
// a monitor pops one entry after each rising edge and compares.
module tb_calc_core;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  calc_if bus_if ();
  calc_core #(.ERR_HOLD(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  // Reference model: calculator behaviour in plain integers.
  localparam int M_A = 0, M_W = 1, M_B = 2, M_S = 3, M_E = 4;
  int ma, mb, mop, mmode, mres, mdisp, mecyc;

  task automatic m_clear();
    ma = 0; mb = 0; mop = 0; mmode = M_A; mres = 0; mdisp = 0; mecyc = 0;
  endtask

  task automatic m_step(input bit v, input int code);
    int r;
    if (v && code == 19) m_clear();
    else if (mmode == M_E) begin
      // mecyc counts cycles err has been visible so far.
      if (HOLD > 0) begin
        if (mecyc == HOLD) m_clear();
        else mecyc++;
      end
    end else if (v && code < 16) begin
      case (mmode)
        M_A: begin ma = code; mdisp = code; end
        M_W: begin mb = code; mdisp = code; mmode = M_B; end
        M_B: begin mb = code; mdisp = code; end
        default: begin ma = code; mb = 0; mdisp = code; mmode = M_A; end
      endcase
    end else if (v && (code == 16 || code == 17)) begin
      case (mmode)
        M_A, M_W: begin mop = (code == 16) ? 1 : 2; mmode = M_W; end
        M_S: if (mres >= 0 && mres <= 15) begin
          ma = mres; mop = (code == 16) ? 1 : 2; mmode = M_W;
        end
        default: ;
      endcase
    end else if (v && code == 18 && mmode == M_B) begin
      r = (mop == 1) ? ma + mb : ma - mb;
      mop = 0;
      if (r > 16) begin
`ifdef CALC_SAT_EN
        mres = 16; mdisp = 16; mmode = M_S;
`else
        mdisp = 0; mmode = M_E; mecyc = 1;
`endif
      end else begin
        mres = r; mdisp = r & 31; mmode = M_S;
      end
    end
  endtask

  function automatic logic [7:0] m_out();
    logic [4:0] s;
    logic [1:0] o;
    s = 5'(mdisp);
    o = 2'(mop);
    return {s, (mmode == M_E), o};
  endfunction

  task automatic drive(input bit v, input int code);
    @(negedge clk);
    bus_if.key_valid = v;
    bus_if.key_code  = 5'(code);
    m_step(v, code);
    exp_q.push_back(m_out());
  endtask

  task automatic key(input int code);
    drive(1'b1, code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 31));
  endtask

  task automatic check_zero(input string name);
    logic [7:0] got;
    got = {bus_if.state, bus_if.err, bus_if.op_ind};
    n_chk++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL %s: got state=%b err=%b op_ind=%b, want all zero",
               name, got[7:3], got[2], got[1:0]);
    end
  endtask

  // Monitor: one expected entry per clock in which a key slot was driven.
  initial begin
    logic [7:0] exp, got;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {bus_if.state, bus_if.err, bus_if.op_ind};
        n_chk++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL outputs @%0t: got state=%b err=%b op_ind=%b, want state=%b err=%b op_ind=%b",
                   $time, got[7:3], got[2], got[1:0], exp[7:3], exp[2], exp[1:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, code;
    bus_if.key_valid = 1'b0;
    bus_if.key_code  = 5'd0;
    m_clear();
    #23;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic add / sub, ignored ADD after negative result.
    key(3); key(16); key(5); key(18); idle(1);
    key(3); key(17); key(9); key(18); key(16); idle(1); key(2);
    // Result 16, then overflow into ERR with digits ignored during ERR.
    key(15); key(16); key(1); key(18); key(17); idle(1);
    key(15); key(16); key(2); key(18); key(7); key(16); idle(5);
    // CLR mid-entry.
    key(7); key(16); key(19); key(2); idle(1);
    // Chained result reused as operand a.
    key(4); key(16); key(4); key(18); key(17); key(3); key(18); idle(1);
    // Operator replacement, EQU ignored outside ENTER_B, 20-31 ignored.
    key(18); key(9); key(22); key(16); key(17); key(18); key(31); key(6); key(18);
    // CLR while in ERR.
    key(14); key(16); key(9); key(18); idle(1); key(19); key(1); idle(1);

    // Async reset mid-entry of b.
    key(4); key(16); key(2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    m_clear();
    @(negedge clk);
    rst = 1'b1;
    key(5); idle(1);

    // Randomised key stream.
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 11);
      if (sel <= 4)       code = $urandom_range(0, 15);
      else if (sel == 5)  code = 16;
      else if (sel == 6)  code = 17;
      else if (sel <= 8)  code = 18;
      else if (sel == 9)  code = $urandom_range(20, 31);
      else if (sel == 10) code = ($urandom_range(0, 3) == 0) ? 19 : 18;
      else                code = $urandom_range(0, 15);
      drive($urandom_range(0, 3) != 0, code);
    end

    @(negedge clk);
    bus_if.key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
